fifo_wr_arbiter: RTL

- Round-robin burst arbiter that shares the single write port of the team's 32-bit FIFO buffer among NREQ producers.
- Selects one requester at a time and holds the grant for up to BURST_LEN accepted words.
- Drives the FIFO's WR/EN/dataIn and backs off on FULL.
- Sits between producer blocks and the FIFO. The FIFO read side is untouched.

---
 rtl/fifo_wr_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the FIFO write port among NREQ producers.
// Optional per-requester accepted-word counters: define FIFO_WR_ARB_WCNT_EN.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 32,
  parameter int BURST_LEN = 8
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*DW-1:0] data_in,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   grant,
  output logic              fifo_WR,
  output logic              fifo_EN,
  output logic [DW-1:0]     fifo_dataIn,
  input  logic              fifo_FULL,
`ifdef FIFO_WR_ARB_WCNT_EN
  input  logic              wcnt_clr,
  output logic [NREQ*16-1:0] wcnt,
`endif
  output logic              busy
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(BURST_LEN + 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t          state, state_nx;
  logic [NREQ-1:0] grant_nx;
  logic [PW-1:0]   owner, owner_nx;
  logic [PW-1:0]   rr_ptr, rr_ptr_nx;
  logic [PW-1:0]   winner;
  logic [CW-1:0]   beat_cnt, beat_nx;
  logic            accept;
  logic            release_grant;
  int              idx;

  // Handshake: a producer holds req[i] with its word on data_in until ack[i]
  // is seen high in the same cycle; ack is the combinational acceptance.
  assign accept = (state == XFER) && req[owner] && !fifo_FULL;

  always_comb begin
    fifo_WR     = accept;
    fifo_EN     = accept;
    fifo_dataIn = accept ? data_in[owner*DW +: DW] : '0;
    ack         = accept ? (NREQ'(1) << owner) : '0;
    busy        = (state == XFER);
  end

  // Scan downward so the requester closest to rr_ptr is written last and wins.
  always_comb begin
    winner = '0;
    idx    = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (req[idx]) winner = PW'(idx);
    end
  end

  always_comb begin
    state_nx      = state;
    grant_nx      = grant;
    owner_nx      = owner;
    rr_ptr_nx     = rr_ptr;
    beat_nx       = beat_cnt;
    release_grant = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nx = XFER;
          owner_nx = winner;
          grant_nx = NREQ'(1) << winner;
          beat_nx  = '0;
        end
      end
      XFER: begin
        if (accept) begin
          beat_nx = beat_cnt + 1'b1;
          if (beat_cnt == CW'(BURST_LEN - 1)) release_grant = 1'b1;
        end else if (!req[owner]) begin
          release_grant = 1'b1;
        end
        if (release_grant) begin
          state_nx  = IDLE;
          grant_nx  = '0;
          rr_ptr_nx = (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nx;
      grant    <= grant_nx;
      owner    <= owner_nx;
      rr_ptr   <= rr_ptr_nx;
      beat_cnt <= beat_nx;
    end
  end

`ifdef FIFO_WR_ARB_WCNT_EN
  // A clear in the same cycle as an ack takes priority over the increment.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wcnt <= '0;
    end else if (wcnt_clr) begin
      wcnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i]) wcnt[i*16 +: 16] <= wcnt[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule
